// File: rtl/spi_frame_master.sv
// SPI mode-0 master: streams a FRAME_BYTES-byte lamp frame MSB-first, pulling bytes over valid/ready.
// Optional trailing two's-complement checksum byte when SPI_FRAME_MASTER_CHECKSUM_EN is defined.
module spi_frame_master #(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_BYTES = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sck,
  output logic       mosi,
  output logic       cs,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BYTE  = 4'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LEAD, SHIFT, TRAIL} state_t;
  state_t state, state_nxt;

  logic [7:0] div_cnt;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [3:0] byte_cnt;
  logic       sck_hi;
  logic       done_q;
  logic       div_zero;
  logic       byte_end;
  logic       last_byte;
  logic       chk_load;
  logic [7:0] chk_byte;

  assign div_zero  = (div_cnt == 8'd0);
  assign byte_end  = (state == SHIFT) && !sck_hi && div_zero && (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == LAST_BYTE);

`ifdef SPI_FRAME_MASTER_CHECKSUM_EN
  logic [7:0] sum;
  logic       chk_active;

  assign chk_load = byte_end && last_byte && !chk_active;
  assign chk_byte = ~sum + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum        <= 8'd0;
      chk_active <= 1'b0;
    end else if (state == IDLE && start) begin
      sum        <= 8'd0;
      chk_active <= 1'b0;
    end else begin
      if (state == FETCH && tx_valid) sum <= sum + tx_data;
      if (chk_load) chk_active <= 1'b1;
    end
  end
`else
  assign chk_load = 1'b0;
  assign chk_byte = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (tx_valid) state_nxt = (byte_cnt == 4'd0) ? LEAD : SHIFT;
      LEAD:  if (div_zero) state_nxt = SHIFT;
      SHIFT: begin
        if (byte_end) begin
          if (!last_byte)    state_nxt = FETCH;
          else if (chk_load) state_nxt = SHIFT;
          else               state_nxt = TRAIL;
        end
      end
      TRAIL: if (div_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cs stays high through the very first FETCH so LEAD provides the full setup time.
  always_comb begin
    tx_ready = (state == FETCH);
    busy     = (state != IDLE);
    sck      = (state == SHIFT) && sck_hi;
    cs       = !((state == LEAD) || (state == SHIFT) || (state == TRAIL) ||
                 ((state == FETCH) && (byte_cnt != 4'd0)));
  end

  assign mosi = shreg[7];
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= 8'd0;
      shreg    <= 8'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 4'd0;
      sck_hi   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == TRAIL) && div_zero;
      case (state)
        IDLE: if (start) byte_cnt <= 4'd0;
        FETCH: begin
          if (tx_valid) begin
            shreg   <= tx_data;
            div_cnt <= DIV_RELOAD;
            bit_cnt <= 3'd0;
            sck_hi  <= 1'b1;
          end
        end
        LEAD: div_cnt <= div_zero ? DIV_RELOAD : div_cnt - 8'd1;
        SHIFT: begin
          if (!div_zero) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_RELOAD;
            if (sck_hi) begin
              // Falling edge: advance mosi, except after bit0 so it holds through a stall.
              sck_hi <= 1'b0;
              if (bit_cnt != 3'd7) shreg <= {shreg[6:0], 1'b0};
            end else if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              sck_hi  <= 1'b1;
            end else if (!last_byte) begin
              byte_cnt <= byte_cnt + 4'd1;
            end else if (chk_load) begin
              shreg   <= chk_byte;
              bit_cnt <= 3'd0;
              sck_hi  <= 1'b1;
            end
          end
        end
        TRAIL: if (!div_zero) div_cnt <= div_cnt - 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: table-driven 7-byte frames plus reset, single-byte and back-to-back sequences.
module tb_spi_frame_master;

`ifdef SPI_FRAME_MASTER_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, tx_valid_a, tx_ready_a, sck_a, mosi_a, cs_a, busy_a, done_a;
  logic [7:0] tx_data_a;
  logic       start_b, tx_valid_b, tx_ready_b, sck_b, mosi_b, cs_b, busy_b, done_b;
  logic [7:0] tx_data_b;

  spi_frame_master #(.CLK_DIV(4), .FRAME_BYTES(7)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .sck(sck_a), .mosi(mosi_a), .cs(cs_a), .busy(busy_a), .done(done_a)
  );

  spi_frame_master #(.CLK_DIV(4), .FRAME_BYTES(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .sck(sck_b), .mosi(mosi_b), .cs(cs_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    int         stall_idx;
    int         stall_len;
    int         inject_at;
    int         exp_done;
    logic [7:0] exp_chk;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input vec_t v, input int id);
    logic [7:0] pay[7];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [7:0] cur = 8'd0;
    int k = 0, fed = 0, stall_rem = v.stall_len, rises = 0, nbits = 0;
    int done_k = -1, done_cnt = 0, cs_hi = 0, busy_falls = 0;
    logic sck_p = 1'b0, busy_p = 1'b0, cs_seen_low = 1'b0, cs_at_done = 1'b0, busy_at_done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pay[i] = 8'(v.base + 8'(i) * v.step);
      exp_q.push_back(pay[i]);
    end
    for (int i = 0; i < CHK_EXTRA; i++) exp_q.push_back(v.exp_chk);

    @(negedge clk);
    start_a = 1'b1; tx_valid_a = 1'b1; tx_data_a = pay[0];
    @(posedge clk);
    while (k < 2000 && !(done_cnt > 0 && k > done_k + 8)) begin
      @(negedge clk);
      start_a = (k == v.inject_at);
      if (k == 0) begin
        check($sformatf("v%0d_busy_rise", id), 32'(busy_a), 32'd1);
        check($sformatf("v%0d_ready_fetch", id), 32'(tx_ready_a), 32'd1);
      end
      if (sck_a && !sck_p && done_cnt == 0) begin
        rises++;
        cur = {cur[6:0], mosi_a};
        nbits++;
        if (nbits % 8 == 0) got.push_back(cur);
      end
      if (!cs_a) cs_seen_low = 1'b1;
      if (cs_seen_low && cs_a && done_cnt == 0 && !done_a) cs_hi++;
      if (busy_p && !busy_a && !done_a) busy_falls++;
      if (done_a) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_k = k; cs_at_done = cs_a; busy_at_done = busy_a;
        end
      end
      sck_p = sck_a; busy_p = busy_a;
      if (tx_ready_a && fed < 7) begin
        if (fed == v.stall_idx && stall_rem > 0) begin
          tx_valid_a = 1'b0; stall_rem--;
        end else begin
          tx_valid_a = 1'b1; tx_data_a = pay[fed]; fed++;
        end
      end else begin
        tx_valid_a = (fed < 7);
        if (fed < 7) tx_data_a = pay[fed];
      end
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    tx_valid_a = 1'b0; start_a = 1'b0;
    check($sformatf("v%0d_rises", id), 32'(rises), 32'(56 + 8 * CHK_EXTRA));
    check($sformatf("v%0d_done_cycle", id), 32'(done_k), 32'(v.exp_done + 64 * CHK_EXTRA));
    check($sformatf("v%0d_done_count", id), 32'(done_cnt), 32'd1);
    check($sformatf("v%0d_cs_high_in_frame", id), 32'(cs_hi), 32'd0);
    check($sformatf("v%0d_busy_glitch", id), 32'(busy_falls), 32'd0);
    check($sformatf("v%0d_cs_at_done", id), 32'(cs_at_done), 32'd1);
    check($sformatf("v%0d_busy_at_done", id), 32'(busy_at_done), 32'd0);
    check($sformatf("v%0d_idle_after", id), 32'(busy_a), 32'd0);
    check($sformatf("v%0d_nbytes", id), 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("v%0d_byte%0d", id, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
  endtask

  initial begin
    int n;
    int exp_bits[8];
    logic bits_q[$];
    int k, done_cnt, k1, k2, rises_b;
    logic sck_p, restart_chk;

    // base, step, stall_idx, stall_len, inject_at, done cycle, checksum byte
    vecs[0] = '{8'h10, 8'h01, -1,  0,  -1, 463, 8'h7B};
    vecs[1] = '{8'h10, 8'h01,  3, 20,  -1, 483, 8'h7B};
    vecs[2] = '{8'h10, 8'h01, -1,  0, 100, 463, 8'h7B};
    vecs[3] = '{8'h01, 8'h01, -1,  0,  -1, 463, 8'hE4};
    vecs[4] = '{8'hF0, 8'h11,  1,  5,  -1, 468, 8'h0B};
    exp_bits = '{1, 0, 1, 0, 0, 1, 0, 1};

    reset = 1'b1;
    start_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = 8'd0;
    start_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", 32'(cs_a), 32'd1);
    check("rst_sck", 32'(sck_a), 32'd0);
    check("rst_mosi", 32'(mosi_a), 32'd0);
    check("rst_ready", 32'(tx_ready_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

    // Reset in the middle of the second byte.
    @(negedge clk);
    tx_valid_a = 1'b1; tx_data_a = 8'h55; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_cs", 32'(cs_a), 32'd1);
    check("midrst_sck", 32'(sck_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_ready", 32'(tx_ready_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    n = 0;
    repeat (600) begin
      @(negedge clk);
      if (done_a || busy_a) n++;
    end
    check("midrst_quiet", 32'(n), 32'd0);
    tx_valid_a = 1'b0;
    run_frame(vecs[0], 5);

    // Single-byte frame, then a restart in the same cycle as done.
    @(negedge clk);
    tx_valid_b = 1'b1; tx_data_b = 8'hA5; start_b = 1'b1;
    @(posedge clk);
    k = 0; done_cnt = 0; k1 = -1; k2 = -1; rises_b = 0; sck_p = 1'b0; restart_chk = 1'b0;
    while (k < 600 && done_cnt < 2) begin
      @(negedge clk);
      start_b = 1'b0;
      if (restart_chk) begin
        check("b_restart_busy", 32'(busy_b), 32'd1);
        restart_chk = 1'b0;
      end
      if (sck_b && !sck_p && done_cnt == 0) begin
        rises_b++;
        bits_q.push_back(mosi_b);
      end
      sck_p = sck_b;
      if (done_b) begin
        done_cnt++;
        if (done_cnt == 1) begin
          k1 = k; start_b = 1'b1; restart_chk = 1'b1;
        end else begin
          k2 = k;
        end
      end
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    tx_valid_b = 1'b0;
    check("b_rises", 32'(rises_b), 32'(8 + 8 * CHK_EXTRA));
    for (int i = 0; i < 8; i++)
      check($sformatf("b_bit%0d", i), (i < bits_q.size()) ? 32'(bits_q[i]) : 32'hDEAD, 32'(exp_bits[i]));
    check("b_done1_cycle", 32'(k1), 32'(73 + 64 * CHK_EXTRA));
    check("b_done2_cycle", 32'(k2 - k1), 32'(74 + 64 * CHK_EXTRA));
    check("b_done_count", 32'(done_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
